// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t       : FSM state encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: one-bit full adder built from two half adders and an OR gate.
//   a, b, cin : input bits and carry in
//   sum       : a xor b xor cin
//   cout      : carry out
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s0, c0, c1;

   halfadder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
   halfadder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

   // Both half-adder carries can never be high together, so OR is the full carry.
   assign cout = c0 | c1;

endmodule

// File: rtl/halfadder.sv
// halfadder: single-bit half adder.
//   a, b  : input bits
//   sum   : a xor b
//   carry : a and b
module halfadder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one result bit per clock.
//   clk, rst        : clock and asynchronous active-high reset
//   start           : begin an addition (sampled only in IDLE)
//   sub             : present only with SERIAL_ADDER_SUB_EN; captured with start, selects a-b
//   a, b            : operands, captured on the accepting edge
//   busy            : high while bits are being shifted through
//   done            : one-cycle pulse when sum/carry_out become valid
//   sum, carry_out  : result and MSB carry, held until the next result
// Optional feature macro: SERIAL_ADDER_SUB_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d, co_q, co_d, done_q, done_d;
   logic             fa_s, fa_c, sub_w;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_w = sub;
`else
   assign sub_w = 1'b0;
`endif

   full_adder_bit u_fa (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .sum(fa_s), .cout(fa_c));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      co_d    = co_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            // Subtraction is a + ~b + 1: invert b and preset the carry.
            a_d     = a;
            b_d     = sub_w ? ~b : b;
            c_d     = sub_w;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            c_d     = fa_c;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? DONE : SHIFT;
         end
         DONE: begin
            sum_d   = res_q;
            co_d    = c_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q == SHIFT);
   assign done      = done_q;
   assign sum       = sum_q;
   assign carry_out = co_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: the operands, captured on the clk edge that accepts start.
REQ-006 The block SHALL have port busy, output, 1 bit: high while an addition is in progress (SHIFT state).
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-008 The block SHALL have port sum, output, WIDTH bits: the result, held stable from done until the next accepted start.
REQ-009 The block SHALL have port carry_out, output, 1 bit: the carry out of the MSB, held with sum.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-011 IDLE with start=1 SHALL load a and b into shift registers, clear the carry flop, zero the bit counter and go to SHIFT.
REQ-012 Each SHIFT cycle SHALL add the operand LSBs plus the carry flop, shift the sum bit into the result MSB (LSB-first), store the new carry and shift both operands right.
REQ-013 SHIFT SHALL last exactly WIDTH cycles, then go to DONE; counter wrap at WIDTH-1 triggers the exit.
REQ-014 DONE SHALL assert done for exactly one cycle, copy the result register to sum and the carry flop to carry_out, then return to IDLE.
REQ-015 Latency: start accepted at edge k SHALL yield done=1 in the cycle following edge k+WIDTH+1.
REQ-016 start in SHIFT or DONE SHALL be ignored, with no effect on the operation in flight.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH on sum, with the overflow bit on carry_out; 0xFF+0x01 (WIDTH=8) gives sum=0x00, carry_out=1.
REQ-018 Changes on a or b outside the accepting edge SHALL have no effect.

Reset
REQ-019 rst=1 SHALL immediately force IDLE, busy=0, done=0, sum=0, carry_out=0, carry flop=0 and counter=0.
REQ-020 rst asserted mid-SHIFT SHALL abort the operation, and no done SHALL follow; the first start after deassertion SHALL be accepted normally.

Configuration
REQ-021 With macro SERIAL_ADDER_SUB_EN defined, the block SHALL add input sub (1 bit, captured with start): sub=1 loads ~b and presets the carry flop to 1, computing a-b; carry_out=1 then means no borrow.
REQ-022 Without SERIAL_ADDER_SUB_EN, the sub port SHALL be absent and the block SHALL only add.

Structure
REQ-023 A shared package serial_adder_pkg SHALL hold the state enum typedef (IDLE/SHIFT/DONE) and the default width constant.
REQ-024 The per-bit add SHALL be a sub-module full_adder_bit (a, b, cin -> sum, cout), built from two instances of the team's existing halfadder plus an OR gate.
REQ-025 Implementation scope SHALL be one FSM, two operand shift registers, one result shift register, a carry flop and a counter.

Verification (WIDTH=8)
REQ-026 Bench case: a=0x35, b=0x0A, start pulse -> busy high for 8 cycles, then done pulse with sum=0x3F, carry_out=0.
REQ-027 Bench case: a=0xFF, b=0x01 -> sum=0x00, carry_out=1; a=0x00, b=0x00 -> sum=0x00, carry_out=0.
REQ-028 Bench case: start re-pulsed in SHIFT cycle 3 with different operands -> first result unchanged, exactly one done pulse.
REQ-029 Bench case: rst asserted in SHIFT cycle 4 -> all outputs 0 immediately, no done; next start with 0x80+0x80 -> sum=0x00, carry_out=1.
REQ-030 Bench case: back-to-back starts (next start one cycle after done) -> both results correct, sum held between done pulses.
REQ-031 Bench case (SERIAL_ADDER_SUB_EN defined): a=0x10, b=0x01, sub=1 -> sum=0x0F, carry_out=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, carry_out=0.
